// File: rtl/multicycle_subtractor.sv
// Sequential WORD-bit subtractor that adds a + ~b + 1 one CHUNK-bit slice per cycle.
// Results and NZCV flags update only once the final slice is summed.
`ifndef WORD
`define WORD 64
`endif

module multicycle_subtractor #(
  parameter int WORD  = `WORD,
  parameter int CHUNK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_in,
  input  logic [WORD-1:0] a_in,
  input  logic [WORD-1:0] b_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [WORD-1:0] sub_out,
  output logic [3:0]      flags_out
);

  localparam int NSL = WORD / CHUNK;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [WORD-1:0] a_q;
  logic [WORD-1:0] nb_q;
  logic [WORD-1:0] sum_q;
  logic [WORD-1:0] sum_d;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic [CHUNK:0]  slice;
  logic [31:0]     base;
  logic            last;
  logic            n_f;
  logic            z_f;
  logic            v_f;

  assign last = (cnt_q == LAST);

  // nb_q holds ~b, so b's sign bit differs from a's when a and nb agree
  always_comb begin
    base  = 32'(cnt_q) * 32'(CHUNK);
    slice = {1'b0, a_q[base +: CHUNK]}
          + {1'b0, nb_q[base +: CHUNK]}
          + {{CHUNK{1'b0}}, carry_q};
    sum_d = sum_q;
    sum_d[base +: CHUNK] = slice[CHUNK-1:0];
    n_f = sum_d[WORD-1];
    z_f = (sum_d == '0);
    v_f = (a_q[WORD-1] == nb_q[WORD-1])
       && (sum_d[WORD-1] != a_q[WORD-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy_out = 1'b0;
    done_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) state_d = COMPUTE;
      end
      COMPUTE: begin
        busy_out = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        busy_out = 1'b1;
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q       <= '0;
      nb_q      <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      sub_out   <= '0;
      flags_out <= 4'b0000;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_in) begin
            a_q     <= a_in;
            nb_q    <= ~b_in;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b1;
          end
        end
        COMPUTE: begin
          sum_q   <= sum_d;
          carry_q <= slice[CHUNK];
          cnt_q   <= cnt_q + 1'b1;
          if (last) begin
            sub_out   <= sum_d;
            flags_out <= {n_f, z_f, slice[CHUNK], v_f};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_subtractor.md
MULTICYCLE_SUBTRACTOR -- requirements
Module: multicycle_subtractor

Interface
REQ-001 The block SHALL take parameter WORD, default `WORD from definitions.vh (64), meaning operand and result width in bits.
REQ-002 The block SHALL take parameter CHUNK, default 16, meaning bits processed per compute cycle; WORD SHALL be an integer multiple of CHUNK.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start_in, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-006 The block SHALL have port a_in, input, WORD, minuend, sampled on the accepting edge.
REQ-007 The block SHALL have port b_in, input, WORD, subtrahend, sampled on the accepting edge.
REQ-008 The block SHALL have port busy_out, output, 1, high while in COMPUTE or DONE.
REQ-009 The block SHALL have port done_out, output, 1, one-cycle pulse marking a valid new result.
REQ-010 The block SHALL have port sub_out, output, WORD, registered result a - b (mod 2^WORD).
REQ-011 The block SHALL have port flags_out, output, 4, registered {N,Z,C,V} for the last result.

Function
REQ-012 The block SHALL implement states IDLE, COMPUTE and DONE.
REQ-013 In IDLE with start_in=1 at edge E0, the block SHALL latch a_in and ~b_in, clear the chunk counter, set the internal carry to 1, and enter COMPUTE.
REQ-014 In IDLE with start_in=0, the block SHALL remain in IDLE with all outputs holding.
REQ-015 Each COMPUTE edge SHALL add one CHUNK-bit slice (LSB slice first) of a and ~b plus the stored carry, store the sum slice, and update the carry from that slice's carry-out.
REQ-016 On the edge that processes the last slice (edge E(WORD/CHUNK), E4 at defaults), the block SHALL load sub_out and flags_out together and enter DONE.
REQ-017 sub_out and flags_out SHALL NOT change at any other time (no partial results visible).
REQ-018 done_out SHALL be 1 exactly for the DONE cycle; at defaults it is high in the cycle following E4.
REQ-019 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-020 start_in SHALL be ignored in COMPUTE and DONE; latched operands SHALL NOT change.
REQ-021 A new start_in SHALL be accepted at the first edge in IDLE, giving a throughput of one operation per WORD/CHUNK+2 cycles.
REQ-022 N SHALL equal result[WORD-1].
REQ-023 Z SHALL be 1 iff result == 0.
REQ-024 C SHALL be the final carry-out (1 = no borrow, i.e. a >= b unsigned).
REQ-025 V SHALL be 1 iff a[WORD-1] != b[WORD-1] and result[WORD-1] != a[WORD-1].
REQ-026 The carry SHALL propagate correctly across slice boundaries, including a borrow rippling through all slices.

Reset
REQ-027 With reset=1 at an edge, the block SHALL enter IDLE, and sub_out=0, flags_out=4'b0000, done_out=0, busy_out=0, and the counter, carry and operand registers SHALL clear.
REQ-028 reset SHALL take priority over start_in and over any in-progress operation; a reset mid-COMPUTE SHALL discard the operation with no done_out pulse.
REQ-029 The first start_in=1 edge after reset deasserts SHALL be accepted normally.

Verification (WORD=64, CHUNK=16)
REQ-030 a=55, b=5, start pulse -> busy 1 for 5 cycles; done_out high 4 cycles after the accepting edge; sub_out=50; flags=0010.
REQ-031 a=5, b=55 -> sub_out=64'hFFFF_FFFF_FFFF_FFCE; flags=1000.
REQ-032 a=b=59000 -> sub_out=0; flags=0110.
REQ-033 a=64'h8000_0000_0000_0000, b=1 -> sub_out=64'h7FFF_FFFF_FFFF_FFFF; flags=0011.
REQ-034 a=64'h1_0000, b=1 -> sub_out=64'hFFFF; flags=0010 (cross-slice borrow); a=0, b=1 -> all ones; flags=1000.
REQ-035 Start a=55, b=5; assert start_in again with a=1, b=24 during COMPUTE; assert reset on the 2nd COMPUTE cycle -> no done_out, outputs 0. Then start a=1, b=24 -> sub_out=64'hFFFF_FFFF_FFFF_FFE9; flags=1000.
